// File: rtl/rr_bus_arbiter.sv
// rtl/rr_bus_arbiter.sv - round-robin bus arbiter driving a 4-to-16 grant decoder
//
// Shares one system bus among up to 16 requesters. The 4-bit grant index and
// grant enable feed the decoder A/E inputs. Each ownership ends on a voluntary
// release, a dropped request, or after MAX_HOLD grant cycles, and is always
// followed by a one-cycle gap with the grant disabled.
//
// Ports:
//   clk_i        system clock, rising edge
//   rst_n_i      asynchronous active-low reset
//   req_i[15:0]  level-held request per requester
//   rel_i        voluntary release strobe from the current owner
//   gnt_idx_o    current/last owner index (decoder A)
//   gnt_en_o     grant valid (decoder E)
//   busy_o       high whenever the arbiter is not idle
//   timeout_o    high during the gap that follows a MAX_HOLD expiry
module rr_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [15:0] req_i,
    input  logic        rel_i,
    output logic [3:0]  gnt_idx_o,
    output logic        gnt_en_o,
    output logic        busy_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam logic [7:0] MaxHold = 8'(MAX_HOLD);

    state_e     state_q, state_d;
    logic [3:0] gnt_idx_q, gnt_idx_d;
    logic [3:0] last_q, last_d;
    logic [7:0] hold_cnt_q, hold_cnt_d;
    logic       timeout_q, timeout_d;

    logic [3:0] winner;
    logic       found;
    logic [3:0] scan_idx;

    // Scan from last+1 upward with 4-bit wraparound; offset 16 wraps to last
    // itself, so a lone requester that just owned the bus is found again.
    always_comb begin
        winner   = last_q;
        found    = 1'b0;
        scan_idx = last_q;
        for (int k = 1; k <= 16; k++) begin
            scan_idx = last_q + 4'(k);
            if (!found && req_i[scan_idx]) begin
                winner = scan_idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_idx_d  = gnt_idx_q;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            ST_OWN: begin
                // Release wins over timeout when both happen on the same edge.
                if (!req_i[gnt_idx_q] || rel_i) begin
                    state_d   = ST_GAP;
                    timeout_d = 1'b0;
                end else if (MaxHold != 8'd0 && hold_cnt_q == MaxHold) begin
                    state_d   = ST_GAP;
                    timeout_d = 1'b1;
                end else if (hold_cnt_q != 8'hFF) begin
                    // Saturate so an unlimited hold never wraps the counter.
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; GAP always lasts one cycle.
                timeout_d = 1'b0;
                if (found) begin
                    state_d    = ST_OWN;
                    gnt_idx_d  = winner;
                    last_d     = winner;
                    hold_cnt_d = 8'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            gnt_idx_q  <= 4'd0;
            last_q     <= 4'd15;
            hold_cnt_q <= 8'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            gnt_idx_q  <= gnt_idx_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    // Outputs decode directly from registered state, so reset clears the
    // grant enable without waiting for a clock edge.
    assign gnt_idx_o = gnt_idx_q;
    assign gnt_en_o  = (state_q == ST_OWN);
    assign busy_o    = (state_q != ST_IDLE);
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// tb/tb_rr_bus_arbiter.sv - self-checking bench for rr_bus_arbiter
module tb_rr_bus_arbiter;

    localparam int MAX_HOLD = 8;

    logic        clk;
    logic        rst_n;
    logic [15:0] req;
    logic        rel;
    logic [3:0]  gnt_idx;
    logic        gnt_en;
    logic        busy;
    logic        timeout;

    int total = 0;
    int bad   = 0;

    rr_bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .req_i    (req),
        .rel_i    (rel),
        .gnt_idx_o(gnt_idx),
        .gnt_en_o (gnt_en),
        .busy_o   (busy),
        .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: phase 0 = no owner/idle, 1 = someone owns the bus,
    // 2 = turnaround cycle. Owner choice is a plain modulo-16 scan.
    int m_phase;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    function automatic int next_owner(int ptr, logic [15:0] r);
        for (int k = 1; k <= 16; k++) begin
            if (r[(ptr + k) % 16]) return (ptr + k) % 16;
        end
        return ptr;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_ptr   = 15;
        m_held  = 0;
        m_to    = 0;
    endtask

    task automatic model_step(logic [15:0] r, logic rl);
        if (m_phase == 1) begin
            if (!r[m_owner] || rl) begin
                m_phase = 2;
                m_to    = 0;
            end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
                m_phase = 2;
                m_to    = 1;
            end else begin
                m_held++;
            end
        end else begin
            m_to = 0;
            if (r != 16'h0) begin
                m_owner = next_owner(m_ptr, r);
                m_ptr   = m_owner;
                m_held  = 1;
                m_phase = 1;
            end else begin
                m_phase = 0;
            end
        end
    endtask

    // One clock: model follows the edge, outputs are sampled at the negedge.
    task automatic tick();
        @(posedge clk);
        model_step(req, rel);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = 16'h0;
        rel   = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        for (int c = 0; c < 10; c++) begin
            tick();
            total++;
            if (gnt_en !== 1'b0 || busy !== 1'b0 || gnt_idx !== 4'd0 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got en=%b busy=%b idx=%0d to=%b want 0 0 0 0",
                         c, gnt_en, busy, gnt_idx, timeout);
            end
        end
    endtask

    task automatic test_single_grant();
        apply_reset();
        req = 16'h0020;
        tick();
        total++;
        if (gnt_en !== 1'b1 || gnt_idx !== 4'd5 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_grant got en=%b idx=%0d busy=%b want 1 5 1", gnt_en, gnt_idx, busy);
        end
        tick();
        tick();
        req = 16'h0;
        tick();
        total++;
        if (gnt_en !== 1'b0 || busy !== 1'b1 || gnt_idx !== 4'd5) begin
            bad++;
            $display("FAIL single_gap got en=%b busy=%b idx=%0d want 0 1 5", gnt_en, busy, gnt_idx);
        end
        tick();
        total++;
        if (gnt_en !== 1'b0 || busy !== 1'b0 || gnt_idx !== 4'd5) begin
            bad++;
            $display("FAIL single_idle got en=%b busy=%b idx=%0d want 0 0 5", gnt_en, busy, gnt_idx);
        end
    endtask

    task automatic test_wrap_order();
        int order[5] = '{0, 1, 4, 15, 0};
        apply_reset();
        req = 16'h8013;
        for (int n = 0; n < 5; n++) begin
            tick();
            total++;
            if (gnt_en !== 1'b1 || gnt_idx !== 4'(order[n])) begin
                bad++;
                $display("FAIL wrap_grant n=%0d got en=%b idx=%0d want 1 %0d", n, gnt_en, gnt_idx, order[n]);
            end
            tick();
            rel = 1'b1;
            tick();
            rel = 1'b0;
            total++;
            if (gnt_en !== 1'b0 || timeout !== 1'b0) begin
                bad++;
                $display("FAIL wrap_gap n=%0d got en=%b to=%b want 0 0", n, gnt_en, timeout);
            end
        end
    endtask

    task automatic test_timeout();
        int en_cycles = 0;
        apply_reset();
        req = 16'h0004;
        for (int c = 0; c < MAX_HOLD; c++) begin
            tick();
            if (gnt_en === 1'b1 && gnt_idx === 4'd2) en_cycles++;
        end
        total++;
        if (en_cycles != MAX_HOLD) begin
            bad++;
            $display("FAIL timeout_hold got %0d grant cycles want %0d", en_cycles, MAX_HOLD);
        end
        tick();
        total++;
        if (gnt_en !== 1'b0 || timeout !== 1'b1) begin
            bad++;
            $display("FAIL timeout_pulse got en=%b to=%b want 0 1", gnt_en, timeout);
        end
        tick();
        total++;
        if (gnt_en !== 1'b1 || gnt_idx !== 4'd2 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL timeout_regrant got en=%b idx=%0d to=%b want 1 2 0", gnt_en, gnt_idx, timeout);
        end
    endtask

    task automatic test_rel_at_limit();
        apply_reset();
        req = 16'h0104;
        for (int c = 0; c < MAX_HOLD; c++) tick();
        total++;
        if (gnt_en !== 1'b1 || gnt_idx !== 4'd2) begin
            bad++;
            $display("FAIL rel_limit_own got en=%b idx=%0d want 1 2", gnt_en, gnt_idx);
        end
        rel = 1'b1;
        tick();
        rel = 1'b0;
        total++;
        if (gnt_en !== 1'b0 || timeout !== 1'b0) begin
            bad++;
            $display("FAIL rel_limit_gap got en=%b to=%b want 0 0", gnt_en, timeout);
        end
        tick();
        total++;
        if (gnt_en !== 1'b1 || gnt_idx !== 4'd8) begin
            bad++;
            $display("FAIL rel_limit_next got en=%b idx=%0d want 1 8", gnt_en, gnt_idx);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        req = 16'h0201;
        tick();
        tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        total++;
        if (gnt_en !== 1'b1 || gnt_idx !== 4'd9) begin
            bad++;
            $display("FAIL async_setup got en=%b idx=%0d want 1 9", gnt_en, gnt_idx);
        end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        total++;
        if (gnt_en !== 1'b0 || busy !== 1'b0 || gnt_idx !== 4'd0) begin
            bad++;
            $display("FAIL async_drop got en=%b busy=%b idx=%0d want 0 0 0", gnt_en, busy, gnt_idx);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req   = 16'h0201;
        tick();
        total++;
        if (gnt_en !== 1'b1 || gnt_idx !== 4'd0) begin
            bad++;
            $display("FAIL async_first got en=%b idx=%0d want 1 0", gnt_en, gnt_idx);
        end
    endtask

    task automatic test_random();
        logic       prev_en;
        logic [3:0] prev_idx;
        apply_reset();
        prev_en  = 1'b0;
        prev_idx = 4'd0;
        for (int c = 0; c < 600; c++) begin
            // Hold the request pattern for a while so timeouts get exercised.
            if ($urandom_range(0, 5) == 0) begin
                req = 16'($urandom) & 16'($urandom);
            end
            rel = ($urandom_range(0, 9) == 0);
            tick();
            total++;
            if (gnt_en !== (m_phase == 1) || busy !== (m_phase != 0) ||
                gnt_idx !== 4'(m_owner) || timeout !== m_to) begin
                bad++;
                $display("FAIL random cyc=%0d got en=%b busy=%b idx=%0d to=%b want %b %b %0d %b",
                         c, gnt_en, busy, gnt_idx, timeout, (m_phase == 1), (m_phase != 0), m_owner, m_to);
            end
            total++;
            if (prev_en && gnt_en && prev_idx !== gnt_idx) begin
                bad++;
                $display("FAIL random_invariant cyc=%0d got idx %0d then %0d want equal", c, prev_idx, gnt_idx);
            end
            prev_en  = gnt_en;
            prev_idx = gnt_idx;
        end
        rel = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 16'h0;
        rel   = 1'b0;
        model_reset();
        test_reset();
        test_single_grant();
        test_wrap_order();
        test_timeout();
        test_rel_at_limit();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
